// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst master and its read buffer.
package ram_burst_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;

  // Read buffer depth and the width needed to count 0..RDBUF_DEPTH entries.
  localparam int RDBUF_DEPTH = 2;
  localparam int RDBUF_CW    = $clog2(RDBUF_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WFLUSH,
    READ,
    RDRAIN
  } state_e;

endpackage

// File: rtl/ram_burst_rdbuf.sv
// Small synchronous FIFO holding RAM read data until the downstream consumer
// takes it. Push and pop may happen in the same cycle.
module ram_burst_rdbuf
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    data_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    head_o,
  output logic [RDBUF_CW-1:0] count_o
);

  localparam int PTR_W = (RDBUF_DEPTH > 1) ? $clog2(RDBUF_DEPTH) : 1;

  logic [WIDTH-1:0]    mem_q [RDBUF_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [RDBUF_CW-1:0] count_q;
  logic                push_en, pop_en;

  // Popping an empty buffer is a no-op; a push into a full buffer is only
  // honoured when a pop frees a slot in the same cycle.
  assign pop_en  = pop_i && (count_q != '0);
  assign push_en = push_i && ((count_q != RDBUF_CW'(RDBUF_DEPTH)) || pop_en);

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the storage is only two words, so it is cleared on reset to give
      // rd_data a defined zero value; larger memories would not be reset.
      for (int i = 0; i < RDBUF_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: every register here uses <= so all updates see the values from
      // before this edge, independent of statement order.
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(RDBUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(RDBUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_q + RDBUF_CW'(push_en) - RDBUF_CW'(pop_en);
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a dual-port synchronous RAM: turns write/read burst
// commands into RAM write-port and read-port cycles with valid/ready streams.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int OCC_W = RDBUF_CW + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;        // next RAM address of the burst
  logic [ADDR_WIDTH-1:0] beats_q;       // beats remaining minus one
  logic                  inflight_q;    // a read was issued last cycle
  logic                  ram_we_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  logic [ADDR_WIDTH-1:0] ram_waddr_q;

  logic                  cmd_fire, wr_fire, rd_pop, issue, last_beat;
  logic [RDBUF_CW-1:0]   buf_count;
  logic [OCC_W-1:0]      occupancy;

  assign last_beat = (beats_q == '0);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_d,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = cmd_write ? WRITE : READ;
      WRITE:   if (wr_fire && last_beat) state_d = WFLUSH;
      WFLUSH:  state_d = IDLE;
      READ:    if (issue && last_beat) state_d = RDRAIN;
      RDRAIN:  if (!inflight_q && (buf_count == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshakes, read issue decision and RAM-facing outputs.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    wr_ready  = (state_q == WRITE);
    busy      = (state_q != IDLE);
    rd_valid  = (buf_count != '0);
    cmd_fire  = cmd_valid && cmd_ready;
    wr_fire   = wr_valid && wr_ready;
    rd_pop    = rd_valid && rd_ready;
    // Buffer slots that will be taken once this cycle's pop and the
    // in-flight RAM read settle; a new read may go out only if one is free.
    // Counting the pop keeps reads at one per cycle while draining.
    occupancy = OCC_W'(buf_count) + OCC_W'(inflight_q) - OCC_W'(rd_pop);
    issue     = (state_q == READ) && (occupancy < OCC_W'(RDBUF_DEPTH));
    // The RAM registers the read address, so presenting the counter directly
    // lands the data on ram_q one cycle after the issue cycle.
    ram_read_addr  = addr_q;
    ram_we         = ram_we_q;
    ram_data       = ram_data_q;
    ram_write_addr = ram_waddr_q;
  end

  // Burst counters and the registered RAM write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      beats_q     <= '0;
      inflight_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_data_q  <= '0;
      ram_waddr_q <= '0;
    end else begin
      ram_we_q   <= wr_fire;
      inflight_q <= issue;
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        beats_q <= cmd_len;
      end else if (wr_fire || issue) begin
        addr_q  <= addr_q + 1'b1;   // wraps modulo the RAM depth
        beats_q <= beats_q - 1'b1;
      end
      if (wr_fire) begin
        ram_data_q  <= wr_data;
        ram_waddr_q <= addr_q;
      end
    end
  end

  ram_burst_rdbuf #(
    .WIDTH (DATA_WIDTH)
  ) u_rdbuf (
    .clock   (clock),
    .reset   (reset),
    .push_i  (inflight_q),
    .data_i  (ram_q),
    .pop_i   (rd_pop),
    .head_o  (rd_data),
    .count_o (buf_count)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 64x8 dual-port RAM.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram_burst_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy;
  logic [7:0] ram_data;
  logic [5:0] ram_write_addr, ram_read_addr;
  logic       ram_we;
  logic [7:0] ram_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ram_burst_master dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .busy           (busy),
    .ram_data       (ram_data),
    .ram_write_addr (ram_write_addr),
    .ram_we         (ram_we),
    .ram_read_addr  (ram_read_addr),
    .ram_q          (ram_q)
  );

  // Behavioural RAM: registered read, old data on read-during-write.
  // Initial contents are 0x80 + address.
  logic [7:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(8'h80 + i);
    ram_q = 8'h00;
  end
  always @(posedge clock) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called on a falling edge while idle; returns one cycle later with the
  // command accepted.
  task automatic start_cmd(input string tag, input logic w, input logic [5:0] a,
                           input logic [5:0] l);
    check({tag, "_cmd_ready_idle"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clock);
    cmd_valid = 1'b0;
    check({tag, "_cmd_ready_busy"}, {cmd_ready, busy}, 2'b01);
  endtask

  task automatic write_burst(input string tag, input logic [5:0] a, input logic [5:0] l,
                             input logic [63:0] d);
    start_cmd(tag, 1'b1, a, l);
    wr_valid = 1'b1;
    wr_data  = d[7:0];
    for (int k = 0; k <= int'(l); k++) begin
      @(negedge clock);
      check($sformatf("%s_we%0d", tag, k), ram_we, 1'b1);
      check($sformatf("%s_waddr%0d", tag, k), ram_write_addr, 6'(a + k));
      check($sformatf("%s_wdata%0d", tag, k), ram_data, d[8*k +: 8]);
      if (k < int'(l)) wr_data = d[8*(k+1) +: 8];
      else             wr_valid = 1'b0;
    end
    check({tag, "_flush_busy"}, busy, 1'b1);
    @(negedge clock);
    check({tag, "_end_we_busy"}, {ram_we, busy}, 2'b00);
  endtask

  task automatic read_burst(input string tag, input logic [5:0] a, input logic [5:0] l,
                            input logic [63:0] d, input logic [31:0] mask, input logic lat);
    int got = 0;
    int first_k = -1;
    int last_k = -1;
    bit saw_we = 1'b0;
    start_cmd(tag, 1'b0, a, l);
    for (int k = 1; k < 200 && got <= int'(l); k++) begin
      rd_ready = (k <= 32) ? mask[k-1] : 1'b1;
      if (ram_we) saw_we = 1'b1;
      if (rd_valid && first_k < 0) first_k = k;
      if (rd_valid && rd_ready) begin
        check($sformatf("%s_rdata%0d", tag, got), rd_data, d[8*got +: 8]);
        got++;
        last_k = k;
      end
      @(negedge clock);
    end
    rd_ready = 1'b0;
    check({tag, "_beat_count"}, got, int'(l) + 1);
    if (lat) begin
      // Accept edge, issue cycle, RAM latency: first beat visible in cycle 3.
      check({tag, "_first_valid"}, first_k, 3);
      check({tag, "_last_beat"}, last_k, 3 + int'(l));
    end
    for (int k = 0; k < 8 && busy; k++) begin
      if (ram_we) saw_we = 1'b1;
      @(negedge clock);
    end
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_no_we"}, saw_we, 1'b0);
  endtask

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [5:0]  len;
    logic [31:0] rdy;   // rd_ready per cycle after accept, LSB first
    logic        lat;   // also check first/last beat timing
    logic [63:0] data;  // beat k in data[8k+:8]: written or expected read
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 6'h05, len: 6'd3, rdy: '1, lat: 1'b0, data: 64'h00000000_44332211};
    vecs[1] = '{wr: 1'b0, addr: 6'h05, len: 6'd3, rdy: '1, lat: 1'b1, data: 64'h00000000_44332211};
    vecs[2] = '{wr: 1'b1, addr: 6'h3E, len: 6'd3, rdy: '1, lat: 1'b0, data: 64'h00000000_A3A2A1A0};
    vecs[3] = '{wr: 1'b0, addr: 6'h3E, len: 6'd3, rdy: '1, lat: 1'b1, data: 64'h00000000_A3A2A1A0};
    vecs[4] = '{wr: 1'b0, addr: 6'h05, len: 6'd7, rdy: 32'h49249249, lat: 1'b0,
                data: 64'h8C8B8A89_44332211};
    vecs[5] = '{wr: 1'b0, addr: 6'h3C, len: 6'd7, rdy: '1, lat: 1'b1, data: 64'h8382A3A2_A1A0BDBC};
    vecs[6] = '{wr: 1'b1, addr: 6'h00, len: 6'd0, rdy: '1, lat: 1'b0, data: 64'h00000000_0000005A};
    vecs[7] = '{wr: 1'b0, addr: 6'h00, len: 6'd0, rdy: '1, lat: 1'b1, data: 64'h00000000_0000005A};

    // Reset held three cycles with a command and write data offered.
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 6'h12;
    cmd_len   = 6'd2;
    wr_valid  = 1'b1;
    wr_data   = 8'hEE;
    rd_ready  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("reset_outputs%0d", c),
            {cmd_ready, wr_ready, rd_valid, busy, ram_we, ram_data, ram_write_addr,
             ram_read_addr, rd_data},
            {1'b1, 4'b0000, 8'h00, 6'h00, 6'h00, 8'h00});
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    rd_ready  = 1'b0;

    // Idle with wr_valid still high: nothing happens.
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check($sformatf("idle_ignore_wr%0d", c),
            {cmd_ready, wr_ready, rd_valid, busy, ram_we}, 5'b10000);
    end
    wr_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr)
        write_burst($sformatf("v%0d", i), vecs[i].addr, vecs[i].len, vecs[i].data);
      else
        read_burst($sformatf("v%0d", i), vecs[i].addr, vecs[i].len, vecs[i].data,
                   vecs[i].rdy, vecs[i].lat);
    end

    // Backpressure stall: rd_ready low, two reads go out then issue stops.
    begin
      logic [63:0] exp_d = 64'h8C8B8A89_44332211;
      int got = 0;
      start_cmd("stall", 1'b0, 6'h05, 6'd7);
      rd_ready = 1'b0;
      for (int k = 1; k < 6; k++) @(negedge clock);
      check("stall_read_addr", ram_read_addr, 6'h07);
      check("stall_rd_valid", rd_valid, 1'b1);
      check("stall_head", rd_data, 8'h11);
      rd_ready = 1'b1;
      for (int k = 0; k < 40 && got < 8; k++) begin
        if (rd_valid) begin
          check($sformatf("stall_rdata%0d", got), rd_data, exp_d[8*got +: 8]);
          got++;
        end
        @(negedge clock);
      end
      rd_ready = 1'b0;
      check("stall_beat_count", got, 8);
      for (int k = 0; k < 8 && busy; k++) @(negedge clock);
      check("stall_idle", busy, 1'b0);
    end

    // Reset in the middle of a 4-beat write after two beats were accepted.
    start_cmd("mid", 1'b1, 6'h28, 6'd3);
    wr_valid = 1'b1;
    wr_data  = 8'hD0;
    @(negedge clock);
    check("mid_we0", {ram_we, ram_write_addr, ram_data}, {1'b1, 6'h28, 8'hD0});
    wr_data = 8'hD1;
    @(negedge clock);
    check("mid_we1", {ram_we, ram_write_addr, ram_data}, {1'b1, 6'h29, 8'hD1});
    wr_data = 8'hD2;
    reset   = 1'b1;
    @(negedge clock);
    check("mid_after_reset", {ram_we, busy, cmd_ready, wr_ready}, 4'b0010);
    reset    = 1'b0;
    wr_valid = 1'b0;
    @(negedge clock);
    check("mid_no_we", {ram_we, busy}, 2'b00);
    read_burst("mid_rd", 6'h28, 6'd3, 64'h00000000_ABAAD1D0, '1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
